switch_cell_segmenter: RTL and testbench
========================================

// Module: switch_cell_segmenter
// PURPOSE
// Ingress segmenter: converts a byte-serial frame (sof/dv/din) into fixed-size cells, MSB-first,
// for the switch-core cell data FIFO, plus one descriptor per frame into the cell pointer FIFO.
// Generalised successor of the 16-byte pre-processor: parametrised cell size, port count and
// cell-count width; pads partial last cells, reports last-cell fill, drops and counts frames
// refused by backpressure, and truncates over-long frames with an error flag.
// PARAMETERS
// CELL_BYTES  16     bytes per cell (power of 2, >=2); CELL_W = 8*CELL_BYTES
// PORT_W      4      portmap width, taken from din[PORT_W-1:0] of first byte (PORT_W<=8)
// CNT_W       8      cell-count field width; max cells per frame = 2**CNT_W-1
// PAD_BYTE    8'h00  fill value for unused bytes of the last cell
// localparam  LB_W = clog2(CELL_BYTES); PTR_W = 1+PORT_W+CNT_W+LB_W
// PORTS
// clk                   in   1       clock
// rstn                  in   1       asynchronous reset, active-low
// sof                   in   1       first byte of frame (valid only with dv=1)
// dv                    in   1       byte valid; high for every byte of frame, low between frames
// din                   in   8       frame byte
// i_cell_data_fifo_dout out  CELL_W  assembled cell, byte k at [CELL_W-1-8k -: 8]
// i_cell_data_fifo_wr   out  1       one-cycle write strobe for cell
// i_cell_ptr_fifo_dout  out  PTR_W   {err, portmap, cell_cnt, last_bytes}
// i_cell_ptr_fifo_wr    out  1       one-cycle write strobe for descriptor
// i_cell_bp             in   1       FIFO backpressure; sampled only at sof
// drop_cnt              out  16      frames dropped on bp; saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, byte_idx=0, cell_cnt=0. Reset mid-frame abandons it;
//   no partial cell/descriptor ever written; rest of that frame (dv=1, no sof) ignored.
// - States: IDLE, FILL, DROP, TRUNC, PTR. Strobes default 0 every cycle (single-cycle pulses).
// - IDLE: sof&dv&!bp -> store din at byte 0, portmap<=din[PORT_W-1:0], byte_idx=1, -> FILL.
//   sof&dv&bp -> drop_cnt+1 (saturating), -> DROP. sof without dv ignored.
// - FILL, dv=1: store din at byte_idx; when byte_idx==CELL_BYTES-1: data_wr=1 next edge,
//   cell_cnt+1, byte_idx=0. Cell bytes not yet overwritten are never visible: dout is presented
//   only with data_wr. sof during FILL is ignored (treated as data). bp ignored after sof.
// - FILL, dv=0, byte_idx>0: unused bytes <= PAD_BYTE, data_wr=1, cell_cnt+1,
//   last_bytes=byte_idx, -> PTR. ptr_wr follows one cycle after this data_wr.
// - FILL, dv=0, byte_idx==0: last_bytes=0 (last cell full); ptr_wr=1 this edge, -> IDLE.
// - PTR: ptr_wr=1, -> IDLE. Descriptor always follows the frame's final data_wr, never same cycle.
// - Truncation: a cell completing with cell_cnt reaching 2**CNT_W-1 while dv stays high -> TRUNC;
//   further bytes discarded; on dv=0: ptr_wr with err=1, cell_cnt=max, last_bytes=0, -> IDLE.
// - DROP: no writes; on dv=0 -> IDLE.
// - Latency: cell data_wr asserted on the edge after its last byte is sampled.
// - Frames need >=1 idle (dv=0) cycle after the dv fall of the previous frame; sof arriving
//   in PTR state is not honoured and that frame is lost (not counted in drop_cnt).
// - cell_cnt/byte_idx clear on return to IDLE.
// TESTING
// 1. 32-byte frame, din[0]=8'h05, bp=0 -> 2 data_wr, ptr={0,4'h5,8'd2,4'd0} 1 cycle after 2nd cell.
// 2. 20-byte frame, port 3 -> cell1 full; cell2 bytes 0-3 data, 4-15 = PAD_BYTE;
//    ptr={0,4'h3,8'd2,4'd4} one cycle after cell2 data_wr.
// 3. bp=1 at sof of 40-byte frame -> no strobes, drop_cnt 0->1; next frame with bp=0 normal;
//    bp toggled mid-frame -> no effect.
// 4. CNT_W=2, 60-byte frame -> 3 data_wr only, ptr err=1, cell_cnt=3, last_bytes=0.
// 5. rstn low after 10 bytes of frame, released with dv still high -> outputs 0, no strobes until
//    next sof; following 16-byte frame -> 1 cell, ptr last_bytes=0.
// 6. 1-byte frame then 17-byte frame with 1-cycle gap -> 1 padded cell+ptr(cnt=1,lb=1);
//    then 2 cells+ptr(cnt=2,lb=1); data checked byte-exact.

Source files
------------

// File: rtl/switch_cell_segmenter_if.sv
// Byte-serial ingress, cell FIFO and pointer FIFO signals of the cell segmenter.
// The module parameters of the segmenter must match the parameters of this interface.
interface switch_cell_segmenter_if #(
  parameter int CELL_BYTES = 16,
  parameter int PORT_W     = 4,
  parameter int CNT_W      = 8
);
  localparam int LB_W   = $clog2(CELL_BYTES);
  localparam int CELL_W = 8 * CELL_BYTES;
  localparam int PTR_W  = 1 + PORT_W + CNT_W + LB_W;

  logic              sof;
  logic              dv;
  logic [7:0]        din;
  logic              i_cell_bp;
  logic [CELL_W-1:0] i_cell_data_fifo_dout;
  logic              i_cell_data_fifo_wr;
  logic [PTR_W-1:0]  i_cell_ptr_fifo_dout;
  logic              i_cell_ptr_fifo_wr;
  logic [15:0]       drop_cnt;

  modport master (
    output sof, dv, din, i_cell_bp,
    input  i_cell_data_fifo_dout, i_cell_data_fifo_wr,
    input  i_cell_ptr_fifo_dout, i_cell_ptr_fifo_wr, drop_cnt
  );

  modport slave (
    input  sof, dv, din, i_cell_bp,
    output i_cell_data_fifo_dout, i_cell_data_fifo_wr,
    output i_cell_ptr_fifo_dout, i_cell_ptr_fifo_wr, drop_cnt
  );
endinterface

// File: rtl/switch_cell_segmenter.sv
// Ingress segmenter: packs a byte-serial frame MSB-first into fixed-size cells and
// emits one {err, portmap, cell_cnt, last_bytes} descriptor per accepted frame.
//
// state | meaning
// IDLE  | waiting for sof with dv
// FILL  | assembling cells from frame bytes
// DROP  | frame refused by backpressure, discarding until dv falls
// TRUNC | cell count exhausted, discarding until dv falls, then error descriptor
// PTR   | padded last cell written, descriptor goes out this cycle
module switch_cell_segmenter #(
  parameter int         CELL_BYTES = 16,
  parameter int         PORT_W     = 4,
  parameter int         CNT_W      = 8,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input logic                    clk,
  input logic                    rstn,
  switch_cell_segmenter_if.slave seg
);
  localparam int LB_W   = $clog2(CELL_BYTES);
  localparam int CELL_W = 8 * CELL_BYTES;
  localparam int PTR_W  = 1 + PORT_W + CNT_W + LB_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LB_W-1:0]  IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, FILL, DROP, TRUNC, PTR} state_t;

  state_t              state_q, state_nxt;
  logic [LB_W-1:0]     byte_idx_q, byte_idx_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [LB_W-1:0]     lb_q, lb_nxt;
  logic [PORT_W-1:0]   port_q, port_nxt;
  logic [CELL_W-1:0]   cell_q, cell_nxt;
  logic [CELL_W-1:0]   cell_wr, cell_pad;
  logic [CELL_W-1:0]   dout_q, dout_nxt;
  logic                data_wr_q, data_wr_nxt;
  logic [PTR_W-1:0]    ptr_q, ptr_nxt;
  logic                ptr_wr_q, ptr_wr_nxt;
  logic [15:0]         drop_q, drop_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      cnt_q      <= '0;
      lb_q       <= '0;
      port_q     <= '0;
      cell_q     <= '0;
      dout_q     <= '0;
      data_wr_q  <= 1'b0;
      ptr_q      <= '0;
      ptr_wr_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      byte_idx_q <= byte_idx_nxt;
      cnt_q      <= cnt_nxt;
      lb_q       <= lb_nxt;
      port_q     <= port_nxt;
      cell_q     <= cell_nxt;
      dout_q     <= dout_nxt;
      data_wr_q  <= data_wr_nxt;
      ptr_q      <= ptr_nxt;
      ptr_wr_q   <= ptr_wr_nxt;
      drop_q     <= drop_nxt;
    end
  end

  // Current cell with the incoming byte merged, and with the unfilled tail padded.
  always_comb begin
    cell_wr  = cell_q;
    cell_pad = cell_q;
    for (int k = 0; k < CELL_BYTES; k++) begin
      if (byte_idx_q == LB_W'(k))
        cell_wr[CELL_W-1-8*k -: 8] = seg.din;
      if (k >= int'(byte_idx_q))
        cell_pad[CELL_W-1-8*k -: 8] = PAD_BYTE;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    byte_idx_nxt = byte_idx_q;
    cnt_nxt      = cnt_q;
    lb_nxt       = lb_q;
    port_nxt     = port_q;
    cell_nxt     = cell_q;
    dout_nxt     = dout_q;
    data_wr_nxt  = 1'b0;
    ptr_nxt      = ptr_q;
    ptr_wr_nxt   = 1'b0;
    drop_nxt     = drop_q;
    case (state_q)
      IDLE: begin
        byte_idx_nxt = '0;
        cnt_nxt      = '0;
        if (seg.sof && seg.dv) begin
          if (!seg.i_cell_bp) begin
            cell_nxt[CELL_W-1 -: 8] = seg.din;
            port_nxt     = seg.din[PORT_W-1:0];
            byte_idx_nxt = LB_W'(1);
            state_nxt    = FILL;
          end else begin
            if (drop_q != 16'hFFFF)
              drop_nxt = drop_q + 16'd1;
            state_nxt = DROP;
          end
        end
      end
      FILL: begin
        if (seg.dv) begin
          // A full set of cells already went out; any further byte truncates.
          if (cnt_q == CNT_MAX) begin
            state_nxt = TRUNC;
          end else begin
            cell_nxt = cell_wr;
            if (byte_idx_q == IDX_LAST) begin
              dout_nxt     = cell_wr;
              data_wr_nxt  = 1'b1;
              cnt_nxt      = cnt_q + CNT_W'(1);
              byte_idx_nxt = '0;
            end else begin
              byte_idx_nxt = byte_idx_q + LB_W'(1);
            end
          end
        end else if (byte_idx_q != '0) begin
          dout_nxt    = cell_pad;
          data_wr_nxt = 1'b1;
          cnt_nxt     = cnt_q + CNT_W'(1);
          lb_nxt      = byte_idx_q;
          state_nxt   = PTR;
        end else begin
          ptr_nxt      = {1'b0, port_q, cnt_q, {LB_W{1'b0}}};
          ptr_wr_nxt   = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = IDLE;
        end
      end
      PTR: begin
        ptr_nxt      = {1'b0, port_q, cnt_q, lb_q};
        ptr_wr_nxt   = 1'b1;
        cnt_nxt      = '0;
        byte_idx_nxt = '0;
        state_nxt    = IDLE;
      end
      TRUNC: begin
        if (!seg.dv) begin
          ptr_nxt      = {1'b1, port_q, CNT_MAX, {LB_W{1'b0}}};
          ptr_wr_nxt   = 1'b1;
          cnt_nxt      = '0;
          byte_idx_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      DROP: begin
        if (!seg.dv)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign seg.i_cell_data_fifo_dout = dout_q;
  assign seg.i_cell_data_fifo_wr   = data_wr_q;
  assign seg.i_cell_ptr_fifo_dout  = ptr_q;
  assign seg.i_cell_ptr_fifo_wr    = ptr_wr_q;
  assign seg.drop_cnt              = drop_q;
endmodule

// File: tb/tb_switch_cell_segmenter.sv
// Randomized bench for switch_cell_segmenter: two instances (CNT_W=8 and CNT_W=2) checked
// against a per-frame model predicting every cell, descriptor and the edge it appears on.
module tb_switch_cell_segmenter;
  localparam int CB = 16;

  typedef struct {
    int           cyc;
    logic [127:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic       sof_v = 1'b0, dv_v = 1'b0, bp_v = 1'b0;
  logic [7:0] din_v = 8'h00;
  int         sel = 0;

  switch_cell_segmenter_if                if0 ();
  switch_cell_segmenter_if #(.CNT_W(2))   if1 ();

  assign if0.sof       = (sel == 0) ? sof_v : 1'b0;
  assign if0.dv        = (sel == 0) ? dv_v  : 1'b0;
  assign if0.din       = (sel == 0) ? din_v : 8'h00;
  assign if0.i_cell_bp = bp_v;
  assign if1.sof       = (sel == 1) ? sof_v : 1'b0;
  assign if1.dv        = (sel == 1) ? dv_v  : 1'b0;
  assign if1.din       = (sel == 1) ? din_v : 8'h00;
  assign if1.i_cell_bp = bp_v;

  switch_cell_segmenter u_dut (.clk(clk), .rstn(rstn), .seg(if0.slave));
  switch_cell_segmenter #(.CNT_W(2)) u_dut_c2 (.clk(clk), .rstn(rstn), .seg(if1.slave));

  ev_t        qd0[$], qd1[$], qp0[$], qp1[$];
  logic [7:0] fb[$];
  int         exp_drop[2] = '{0, 0};
  int         lost_edge[2] = '{-1, -1};

  task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [127:0] cell_val(input int i, input int len);
    logic [127:0] v = '0;
    for (int k = 0; k < CB; k++) begin
      int idx = i * CB + k;
      v = (v << 8) | 128'((idx < len) ? fb[idx] : 8'h00);
    end
    return v;
  endfunction

  function automatic logic [127:0] ptr_val(input int cw, input int err, input int port,
                                           input int cnt, input int lb);
    return (128'(err) << (8 + cw)) | (128'(port) << (4 + cw)) | (128'(cnt) << 4) | 128'(lb);
  endfunction

  function automatic void push_ev(input int s, input bit is_ptr, input int c, input logic [127:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    if (s == 0) begin
      if (is_ptr) qp0.push_back(e); else qd0.push_back(e);
    end else begin
      if (is_ptr) qp1.push_back(e); else qd1.push_back(e);
    end
  endfunction

  // Whole-frame expectation from length, cell size and the count limit; ps = sof edge.
  function automatic void model_frame(input int s, input int len, input bit bp, input int ps);
    int cw, maxc, need, full, rem, port;
    cw = (s == 0) ? 8 : 2;
    if (ps == lost_edge[s]) return;
    if (bp) begin
      if (exp_drop[s] != 65535) exp_drop[s]++;
      return;
    end
    port = int'(fb[0] & 8'h0F);
    maxc = (1 << cw) - 1;
    need = (len + CB - 1) / CB;
    if (need > maxc) begin
      for (int i = 0; i < maxc; i++) push_ev(s, 1'b0, ps + CB * i + CB - 1, cell_val(i, len));
      push_ev(s, 1'b1, ps + len, ptr_val(cw, 1, port, maxc, 0));
    end else begin
      full = len / CB;
      rem  = len % CB;
      for (int i = 0; i < full; i++) push_ev(s, 1'b0, ps + CB * i + CB - 1, cell_val(i, len));
      if (rem > 0) begin
        push_ev(s, 1'b0, ps + len, cell_val(full, len));
        push_ev(s, 1'b1, ps + len + 1, ptr_val(cw, 0, port, need, rem));
        lost_edge[s] = ps + len + 1;
      end else begin
        push_ev(s, 1'b1, ps + len, ptr_val(cw, 0, port, full, 0));
      end
    end
  endfunction

  task automatic send_frame(input int s, input int len, input bit bp, input int gap, input int first);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    if (first >= 0) fb[0] = 8'(first);
    sel = s;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sof_v = (i == 0);
      dv_v  = 1'b1;
      din_v = fb[i];
      bp_v  = (i == 0) ? bp : 1'($urandom);
      if (i == 0) model_frame(s, len, bp, cyc + 1);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      dv_v  = 1'b0;
      sof_v = 1'($urandom);
      din_v = 8'($urandom);
      bp_v  = 1'($urandom);
    end
    chk_val("drop_cnt", (s == 0) ? if0.drop_cnt : if1.drop_cnt, 128'(exp_drop[s]));
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      chk_val("rst_data_wr0", if0.i_cell_data_fifo_wr, 0);
      chk_val("rst_ptr_wr0", if0.i_cell_ptr_fifo_wr, 0);
      chk_val("rst_dout0", if0.i_cell_data_fifo_dout, 0);
      chk_val("rst_ptr0", if0.i_cell_ptr_fifo_dout, 0);
      chk_val("rst_drop0", if0.drop_cnt, 0);
      chk_val("rst_drop1", if1.drop_cnt, 0);
    end else begin
      if (qd0.size() > 0 && qd0[0].cyc < cyc) begin
        chk_val("cell_missing0", cyc, qd0[0].cyc);
        void'(qd0.pop_front());
      end
      if (qp0.size() > 0 && qp0[0].cyc < cyc) begin
        chk_val("ptr_missing0", cyc, qp0[0].cyc);
        void'(qp0.pop_front());
      end
      if (qd1.size() > 0 && qd1[0].cyc < cyc) begin
        chk_val("cell_missing1", cyc, qd1[0].cyc);
        void'(qd1.pop_front());
      end
      if (qp1.size() > 0 && qp1[0].cyc < cyc) begin
        chk_val("ptr_missing1", cyc, qp1[0].cyc);
        void'(qp1.pop_front());
      end
      if (if0.i_cell_data_fifo_wr) begin
        if (qd0.size() == 0) chk_val("data_unexp0", if0.i_cell_data_fifo_wr, 0);
        else begin
          ev_t e;
          e = qd0.pop_front();
          chk_val("cell_cyc0", cyc, e.cyc);
          chk_val("cell_data0", if0.i_cell_data_fifo_dout, e.val);
        end
      end
      if (if0.i_cell_ptr_fifo_wr) begin
        if (qp0.size() == 0) chk_val("ptr_unexp0", if0.i_cell_ptr_fifo_wr, 0);
        else begin
          ev_t e;
          e = qp0.pop_front();
          chk_val("ptr_cyc0", cyc, e.cyc);
          chk_val("ptr_val0", if0.i_cell_ptr_fifo_dout, e.val);
        end
      end
      if (if1.i_cell_data_fifo_wr) begin
        if (qd1.size() == 0) chk_val("data_unexp1", if1.i_cell_data_fifo_wr, 0);
        else begin
          ev_t e;
          e = qd1.pop_front();
          chk_val("cell_cyc1", cyc, e.cyc);
          chk_val("cell_data1", if1.i_cell_data_fifo_dout, e.val);
        end
      end
      if (if1.i_cell_ptr_fifo_wr) begin
        if (qp1.size() == 0) chk_val("ptr_unexp1", if1.i_cell_ptr_fifo_wr, 0);
        else begin
          ev_t e;
          e = qp1.pop_front();
          chk_val("ptr_cyc1", cyc, e.cyc);
          chk_val("ptr_val1", if1.i_cell_ptr_fifo_dout, e.val);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(0, 32, 1'b0, 2, 8'h05);
    send_frame(0, 20, 1'b0, 3, 8'h03);
    send_frame(0, 40, 1'b1, 2, -1);
    send_frame(0, 24, 1'b0, 3, -1);
    send_frame(1, 60, 1'b0, 2, -1);
    send_frame(1, 48, 1'b0, 2, -1);
    send_frame(0, 1, 1'b0, 2, -1);
    send_frame(0, 17, 1'b0, 2, -1);
    send_frame(0, 5, 1'b0, 1, -1);
    send_frame(0, 16, 1'b0, 2, -1);

    // Abandon a frame with reset after 10 bytes; its tail must be ignored.
    repeat (4) @(negedge clk);
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sof_v = (i == 0);
      dv_v  = 1'b1;
      din_v = 8'($urandom);
      bp_v  = 1'b0;
    end
    @(negedge clk);
    sof_v = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    exp_drop[0]  = 0;
    exp_drop[1]  = 0;
    lost_edge[0] = -1;
    lost_edge[1] = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din_v = 8'($urandom);
    end
    @(negedge clk);
    dv_v = 1'b0;
    @(negedge clk);
    send_frame(0, 16, 1'b0, 2, -1);

    for (int f = 0; f < 40; f++)
      send_frame(0, int'($urandom_range(1, 50)), ($urandom_range(0, 4) == 0),
                 int'($urandom_range(1, 3)), -1);
    for (int f = 0; f < 25; f++)
      send_frame(1, int'($urandom_range(1, 70)), ($urandom_range(0, 4) == 0),
                 int'($urandom_range(1, 3)), -1);

    repeat (8) @(negedge clk);
    chk_val("cells_left0", qd0.size(), 0);
    chk_val("ptrs_left0", qp0.size(), 0);
    chk_val("cells_left1", qd1.size(), 0);
    chk_val("ptrs_left1", qp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
